// File: rtl/serial_adder_32bit.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder_32bit
// Brief    : Multi-cycle 32-bit adder with carry-in/carry-out. Adds one
//            SLICE_W-bit slice per clock and ripples the carry through a
//            register. Uses a start/busy/done handshake.
// Options  : SERIAL_ADDER_OVF_EN adds the signed-overflow output 'ovf'.
// Revision : 1.0 - initial release
// ============================================================================
module serial_adder_32bit #(
  parameter int SLICE_W = 8   // 1, 2, 4, 8, 16 or 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Cin,
  output logic        busy,
  output logic        done,
  output logic [31:0] S,
  output logic        Cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic        ovf
`endif
);

  localparam int c_nslice = 32 / SLICE_W;
  localparam int c_kw     = (c_nslice > 1) ? $clog2(c_nslice) : 1;
  localparam logic [c_kw-1:0] c_klast = c_kw'(c_nslice - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [31:0]     r_a;
  logic [31:0]     r_b;
  logic [c_kw-1:0] r_k;
  logic            r_carry;

  logic [4:0]         w_base;
  logic [SLICE_W-1:0] w_a_sl;
  logic [SLICE_W-1:0] w_b_sl;
  logic [SLICE_W:0]   w_sum;

  // Slice adder: current slice of both operands plus the stored carry
  always_comb begin
    w_base = 5'(32'(r_k) * SLICE_W);
    w_a_sl = r_a[w_base +: SLICE_W];
    w_b_sl = r_b[w_base +: SLICE_W];
    w_sum  = {1'b0, w_a_sl} + {1'b0, w_b_sl} + {{SLICE_W{1'b0}}, r_carry};
  end

`ifdef SERIAL_ADDER_OVF_EN
  // On the last slice w_sum[SLICE_W-1] is the final bit 31 of the sum
  logic w_ovf;
  assign w_ovf = (r_a[31] == r_b[31]) && (w_sum[SLICE_W-1] != r_a[31]);
`endif

  // Control FSM, operand capture, slice write-back and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_k     <= '0;
      r_carry <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      S       <= '0;
      Cout    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf     <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          done <= 1'b0;
          if (start) begin
            // Cout/ovf keep the previous result; only S is cleared here
            r_a     <= A;
            r_b     <= B;
            r_carry <= Cin;
            r_k     <= '0;
            S       <= '0;
            busy    <= 1'b1;
            r_state <= ST_RUN;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          S[w_base +: SLICE_W] <= w_sum[SLICE_W-1:0];
          r_carry              <= w_sum[SLICE_W];
          if (r_k == c_klast) begin
            r_k     <= '0;
            Cout    <= w_sum[SLICE_W];
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= ST_DONE;
`ifdef SERIAL_ADDER_OVF_EN
            ovf     <= w_ovf;
`endif
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
